// File: rtl/instr_fetch.sv
// Instruction fetch stage: one-cycle-latency memory interface, a 2-entry
// {instr, pc} buffer toward decode, and flush/redirect from execute.
module instr_fetch #(
  parameter int                          INSTR_ADDR_WIDTH = 32,
  parameter int                          INSTR_WORD_WIDTH = 32,
  parameter logic [INSTR_ADDR_WIDTH-1:0] BOOT_ADDR        = 32'h0000_0000
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  output logic                        fetch_en_o,
  output logic [INSTR_ADDR_WIDTH-1:0] fetch_addr_o,
  input  logic [INSTR_WORD_WIDTH-1:0] fetch_rdata_i,
  input  logic                        redirect_i,
  input  logic [INSTR_ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                        instr_valid_o,
  input  logic                        instr_ready_i,
  output logic [INSTR_WORD_WIDTH-1:0] instr_o,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_pc_o
);

  localparam logic [INSTR_ADDR_WIDTH-1:0] BOOT_ALIGNED = {BOOT_ADDR[INSTR_ADDR_WIDTH-1:2], 2'b00};

  logic [INSTR_ADDR_WIDTH-1:0] r_pc;
  logic                        r_pend;
  logic [INSTR_ADDR_WIDTH-1:0] r_pend_pc;
  logic [1:0]                  r_cnt;
  logic                        r_rd_ptr;
  logic                        r_wr_ptr;
  logic [INSTR_WORD_WIDTH-1:0] r_buf_instr [2];
  logic [INSTR_ADDR_WIDTH-1:0] r_buf_pc    [2];

  logic       w_pop;
  logic       w_push;
  logic [2:0] w_occ;

  assign instr_valid_o = !rst_i && (r_cnt != 2'd0);
  assign w_pop         = instr_valid_o && instr_ready_i;
  assign w_push        = r_pend && !redirect_i;

  // Occupancy after this cycle's pop; the in-flight response still needs a slot.
  assign w_occ = {1'b0, r_cnt} + {2'b00, r_pend} - {2'b00, w_pop};

  assign fetch_en_o   = !rst_i && !redirect_i && (w_occ < 3'd2);
  assign fetch_addr_o = {r_pc[INSTR_ADDR_WIDTH-1:2], 2'b00};
  assign instr_o      = r_buf_instr[r_rd_ptr];
  assign instr_pc_o   = r_buf_pc[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc      <= BOOT_ALIGNED;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
      r_cnt     <= 2'd0;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
    end else if (redirect_i) begin
      r_pc     <= {redirect_addr_i[INSTR_ADDR_WIDTH-1:2], 2'b00};
      r_pend   <= 1'b0;
      r_cnt    <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (fetch_en_o) begin
        r_pc      <= r_pc + INSTR_ADDR_WIDTH'(4);
        r_pend    <= 1'b1;
        r_pend_pc <= fetch_addr_o;
      end else begin
        r_pend <= 1'b0;
      end
      if (w_push) r_wr_ptr <= !r_wr_ptr;
      if (w_pop)  r_rd_ptr <= !r_rd_ptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Buffer storage carries no reset; r_cnt alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_buf_instr[r_wr_ptr] <= fetch_rdata_i;
      r_buf_pc[r_wr_ptr]    <= r_pend_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the fetch stream.
module tb_instr_fetch;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        fetch_en_o;
  logic [31:0] fetch_addr_o;
  logic [31:0] fetch_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  instr_fetch #(
    .INSTR_ADDR_WIDTH(32),
    .INSTR_WORD_WIDTH(32),
    .BOOT_ADDR(BOOT)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .fetch_en_o(fetch_en_o),
    .fetch_addr_o(fetch_addr_o),
    .fetch_rdata_i(fetch_rdata_i),
    .redirect_i(redirect_i),
    .redirect_addr_i(redirect_addr_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o(instr_o),
    .instr_pc_o(instr_pc_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Model state: buffered PCs, the PC in flight (0 or 1 entries), next fetch PC.
  logic [31:0] m_fifo [$];
  logic [31:0] m_infl [$];
  logic [31:0] m_next = BOOT;

  logic        mem_prev_en   = 1'b0;
  logic [31:0] mem_prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares DUT outputs with the model for the current cycle, then advances the model.
  task automatic model_cycle();
    bit          v_e, pop_e, en_e;
    int          occ;
    logic [31:0] pc_e;
    v_e   = !rst_i && (m_fifo.size() != 0);
    pop_e = v_e && instr_ready_i;
    occ   = m_fifo.size() + m_infl.size() - (pop_e ? 1 : 0);
    en_e  = !rst_i && !redirect_i && (occ < 2);
    check("fetch_en", {31'b0, fetch_en_o}, {31'b0, en_e});
    check("instr_valid", {31'b0, instr_valid_o}, {31'b0, v_e});
    if (!rst_i) check("fetch_addr", fetch_addr_o, m_next);
    if (v_e) begin
      pc_e = m_fifo[0];
      check("instr_pc", instr_pc_o, pc_e);
      check("instr", instr_o, mem_word(pc_e));
    end
    if (rst_i) begin
      m_fifo.delete(); m_infl.delete(); m_next = BOOT;
    end else if (redirect_i) begin
      m_fifo.delete(); m_infl.delete(); m_next = {redirect_addr_i[31:2], 2'b00};
    end else begin
      if (pop_e) void'(m_fifo.pop_front());
      if (m_infl.size() != 0) m_fifo.push_back(m_infl.pop_front());
      if (en_e) begin
        m_infl.push_back(m_next);
        m_next = m_next + 32'd4;
      end
    end
  endtask

  // One clock cycle: drive inputs and the memory response, then check at negedge+1.
  task automatic step(input bit rst, input bit redir, input logic [31:0] raddr, input bit rdy);
    @(negedge clk_i);
    rst_i           = rst;
    redirect_i      = redir;
    redirect_addr_i = raddr;
    instr_ready_i   = rdy;
    fetch_rdata_i   = mem_prev_en ? mem_word(mem_prev_addr) : $urandom;
    #1;
    mem_prev_en   = fetch_en_o;
    mem_prev_addr = fetch_addr_o;
    model_cycle();
  endtask

  initial begin
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    check("lit_rst_en", {31'b0, fetch_en_o}, 32'd0);
    check("lit_rst_valid", {31'b0, instr_valid_o}, 32'd0);

    // Boot stream
    step(0, 0, 0, 1);
    check("lit_boot_en", {31'b0, fetch_en_o}, 32'd1);
    check("lit_boot_addr", fetch_addr_o, 32'h0);
    step(0, 0, 0, 1);
    check("lit_boot_addr1", fetch_addr_o, 32'h4);
    check("lit_boot_novalid", {31'b0, instr_valid_o}, 32'd0);
    step(0, 0, 0, 1);
    check("lit_first_pc", instr_pc_o, 32'h0);
    check("lit_first_instr", instr_o, mem_word(32'h0));
    step(0, 0, 0, 1);
    check("lit_second_pc", instr_pc_o, 32'h4);

    // Stall for 10 cycles, then drain
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    check("lit_stall_en", {31'b0, fetch_en_o}, 32'd0);
    check("lit_stall_valid", {31'b0, instr_valid_o}, 32'd1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // Redirect to unaligned target while stalled and full
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(0, 1, 32'h0000_0103, 0);
    check("lit_redir_noissue", {31'b0, fetch_en_o}, 32'd0);
    step(0, 0, 0, 1);
    check("lit_redir_addr", fetch_addr_o, 32'h0000_0100);
    check("lit_redir_novalid", {31'b0, instr_valid_o}, 32'd0);
    step(0, 0, 0, 1);
    check("lit_redir_novalid2", {31'b0, instr_valid_o}, 32'd0);
    step(0, 0, 0, 1);
    check("lit_redir_pc", instr_pc_o, 32'h0000_0100);

    // Back-to-back redirects
    step(0, 1, 32'h0000_0200, 1);
    step(0, 1, 32'h0000_0300, 1);
    step(0, 0, 0, 1);
    check("lit_b2b_addr0", fetch_addr_o, 32'h0000_0300);
    step(0, 0, 0, 1);
    check("lit_b2b_addr1", fetch_addr_o, 32'h0000_0304);
    step(0, 0, 0, 1);
    check("lit_b2b_pc0", instr_pc_o, 32'h0000_0300);
    step(0, 0, 0, 1);
    check("lit_b2b_pc1", instr_pc_o, 32'h0000_0304);

    // Address wrap
    step(0, 1, 32'hFFFF_FFF8, 1);
    step(0, 0, 0, 1);
    check("lit_wrap_a0", fetch_addr_o, 32'hFFFF_FFF8);
    step(0, 0, 0, 1);
    check("lit_wrap_a1", fetch_addr_o, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    check("lit_wrap_a2", fetch_addr_o, 32'h0000_0000);
    check("lit_wrap_p0", instr_pc_o, 32'hFFFF_FFF8);
    step(0, 0, 0, 1);
    check("lit_wrap_p1", instr_pc_o, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    check("lit_wrap_p2", instr_pc_o, 32'h0000_0000);

    // One-cycle reset with the buffer full
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    check("lit_full_valid", {31'b0, instr_valid_o}, 32'd1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    check("lit_rst_mid_valid", {31'b0, instr_valid_o}, 32'd0);
    check("lit_rst_mid_addr", fetch_addr_o, BOOT);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 15) == 0),
           $urandom,
           ($urandom_range(0, 9) < 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
